// File: rtl/vector_pkg.sv
// Shared types and helpers for the multi-list vector fetcher: FSM state
// encoding, display-list entry flags and the frame clamp.
package vector_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FSTART   = 4'd1,
        S_FETCH    = 4'd2,
        S_MEMWAIT  = 4'd3,
        S_DECODE   = 4'd4,
        S_SEND     = 4'd5,
        S_WAITDONE = 4'd6,
        S_NEXTLIST = 4'd7
    } state_t;

    typedef struct packed {
        logic line;
        logic pos;
        logic last;
    } entry_flags_t;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/vector_xform.sv
// One axis of the entry transform: unsigned coordinate plus signed per-list
// offset, saturated to the frame window (never wraps).
module vector_xform
    import vector_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int OUT_WIDTH = 8,
    parameter int FRAME_MIN = 0,
    parameter int FRAME_MAX = 255
) (
    input  logic        [COORD_W-1:0] coord_i,
    input  logic signed [COORD_W:0]   off_i,
    output logic signed [OUT_WIDTH:0] coord_o
);

    logic signed [COORD_W+1:0] sum;

    // Two guard bits keep max coordinate + max offset and 0 + min offset exact.
    always_comb begin
        sum     = $signed({2'b00, coord_i}) + $signed({off_i[COORD_W], off_i});
        coord_o = (OUT_WIDTH+1)'(clamp(int'(sum), FRAME_MIN, FRAME_MAX));
    end

endmodule

// File: rtl/vector_list_seq.sv
// Multi-list display-list walker: fetches entries, offsets and clamps them,
// and hands each DRAW to the downstream line drawer via go/busy/done.
module vector_list_seq
    import vector_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int ADR_WIDTH = 8,
    parameter int NUM_LISTS = 4,
    parameter int MAX_LEN   = 64,
    parameter int FRAME_MIN = 0,
    parameter int FRAME_MAX = 255,
    parameter int OUT_WIDTH = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic        [NUM_LISTS*ADR_WIDTH-1:0]                 list_base,
    input  logic        [NUM_LISTS-1:0]                           list_en,
    input  logic        [NUM_LISTS*(COORD_W+1)-1:0]               list_offx,
    input  logic        [NUM_LISTS*(COORD_W+1)-1:0]               list_offy,
    output logic        [ADR_WIDTH-1:0]                           adr,
    input  logic        [COORD_W-1:0]                             x,
    input  logic        [COORD_W-1:0]                             y,
    input  logic                                                  line,
    input  logic                                                  pos,
    input  logic                                                  last,
    output logic                                                  go,
    output logic signed [OUT_WIDTH:0]                             stax,
    output logic signed [OUT_WIDTH:0]                             stay,
    output logic signed [OUT_WIDTH:0]                             endx,
    output logic signed [OUT_WIDTH:0]                             endy,
    input  logic                                                  busy,
    input  logic                                                  done,
    output logic                                                  vector_reset,
    output logic        [((NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1)-1:0] cur_list,
    output logic                                                  len_err,
    output logic        [3:0]                                     state_debug
);

    localparam int LIST_W = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1;
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic signed [OUT_WIDTH:0] PEN_HOME = (OUT_WIDTH+1)'(FRAME_MIN);

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NUM_LISTS-1:0]      en_q;
    logic [LIST_W-1:0]         cur_q;
    logic                      last_q;
    logic                      go_q;
    logic                      vr_q;
    logic                      len_err_q;
    logic [ADR_WIDTH-1:0]      adr_q;
    logic signed [OUT_WIDTH:0] pen_x_q, pen_y_q;
    logic signed [OUT_WIDTH:0] stax_q, stay_q, endx_q, endy_q;

    logic [ADR_WIDTH-1:0]      cur_base;
    logic signed [COORD_W:0]   cur_offx, cur_offy;
    logic signed [OUT_WIDTH:0] tx, ty;
    logic [LIST_W-1:0]         first_list, next_list;
    logic                      next_found;
    logic                      term_last, list_done;
    entry_flags_t              flags;

    assign flags = '{line: line, pos: pos, last: last};

    always_comb begin
        cur_base   = list_base[int'(cur_q)*ADR_WIDTH +: ADR_WIDTH];
        cur_offx   = $signed(list_offx[int'(cur_q)*(COORD_W+1) +: COORD_W+1]);
        cur_offy   = $signed(list_offy[int'(cur_q)*(COORD_W+1) +: COORD_W+1]);
        first_list = '0;
        next_list  = '0;
        next_found = 1'b0;
        // Descending scans so the lowest qualifying index wins.
        for (int i = NUM_LISTS-1; i >= 0; i--) begin
            if (list_en[i]) first_list = LIST_W'(i);
            if (en_q[i] && (i > int'(cur_q))) begin
                next_list  = LIST_W'(i);
                next_found = 1'b1;
            end
        end
        // The last flag comes from the bus in DECODE, from the latch after a draw.
        term_last = (state_q == S_DECODE) ? flags.last : last_q;
        list_done = term_last || (idx_q == IDX_W'(MAX_LEN-1));
    end

    vector_xform #(
        .COORD_W(COORD_W), .OUT_WIDTH(OUT_WIDTH),
        .FRAME_MIN(FRAME_MIN), .FRAME_MAX(FRAME_MAX)
    ) u_xform_x (
        .coord_i(x), .off_i(cur_offx), .coord_o(tx)
    );

    vector_xform #(
        .COORD_W(COORD_W), .OUT_WIDTH(OUT_WIDTH),
        .FRAME_MIN(FRAME_MIN), .FRAME_MAX(FRAME_MAX)
    ) u_xform_y (
        .coord_i(y), .off_i(cur_offy), .coord_o(ty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            en_q      <= '0;
            cur_q     <= '0;
            last_q    <= 1'b0;
            go_q      <= 1'b0;
            vr_q      <= 1'b0;
            len_err_q <= 1'b0;
            adr_q     <= '0;
            pen_x_q   <= '0;
            pen_y_q   <= '0;
            stax_q    <= '0;
            stay_q    <= '0;
            endx_q    <= '0;
            endy_q    <= '0;
        end else begin
            go_q <= 1'b0;
            vr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    adr_q <= '0;
                    if (|list_en) state_q <= S_FSTART;
                end
                S_FSTART: begin
                    if (|list_en) begin
                        vr_q    <= 1'b1;
                        en_q    <= list_en;
                        cur_q   <= first_list;
                        idx_q   <= '0;
                        pen_x_q <= PEN_HOME;
                        pen_y_q <= PEN_HOME;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    adr_q   <= cur_base + ADR_WIDTH'(idx_q);
                    state_q <= S_MEMWAIT;
                end
                S_MEMWAIT: state_q <= S_DECODE;
                S_DECODE: begin
                    last_q <= flags.last;
                    if (flags.line && !flags.pos) begin
                        stax_q  <= pen_x_q;
                        stay_q  <= pen_y_q;
                        endx_q  <= tx;
                        endy_q  <= ty;
                        pen_x_q <= tx;
                        pen_y_q <= ty;
                        state_q <= S_SEND;
                    end else begin
                        if (flags.pos) begin
                            pen_x_q <= tx;
                            pen_y_q <= ty;
                        end
                        if (list_done) begin
                            if (!term_last) len_err_q <= 1'b1;
                            state_q <= S_NEXTLIST;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_SEND: begin
                    if (!busy) begin
                        go_q    <= 1'b1;
                        state_q <= S_WAITDONE;
                    end
                end
                S_WAITDONE: begin
                    if (done) begin
                        if (list_done) begin
                            if (!term_last) len_err_q <= 1'b1;
                            state_q <= S_NEXTLIST;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_NEXTLIST: begin
                    pen_x_q <= PEN_HOME;
                    pen_y_q <= PEN_HOME;
                    idx_q   <= '0;
                    if (next_found) begin
                        cur_q   <= next_list;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_FSTART;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign adr          = adr_q;
    assign go           = go_q;
    assign stax         = stax_q;
    assign stay         = stay_q;
    assign endx         = endx_q;
    assign endy         = endy_q;
    assign vector_reset = vr_q;
    assign cur_list     = cur_q;
    assign len_err      = len_err_q;
    assign state_debug  = state_q;

endmodule
